// File: rtl/exe_stage_mul.sv
// exe_stage_mul: pipeline execute stage with an iterative shift-add multiplier.
// Selects ALU operand B (eqb or eimm32), computes the result, and registers the
// result, eqb and control fields into the EXE/MEM boundary (m* outputs).
//
// Optional feature macro: EXE_MUL_EN
//   defined   - IDLE/BUSY/DONE multiplier FSM is built; aluc B multiplies and
//               stalls upstream (estall) for DATA_W+1 cycles.
//   undefined - no multiplier; estall is tied low and aluc B yields 0.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   ewreg, em2reg, ewmem    E-stage control fields
//   ealuimm                 1 selects eimm32 as operand B, 0 selects eqb
//   ealuc                   ALU operation code
//   edestReg                destination register index
//   eqa, eqb, eimm32        operand A, register B, sign-extended immediate
//   estall                  combinational stall request to PC, IF/ID, ID/EXE
//   mwreg, mm2reg, mwmem    registered control fields
//   mdestReg, mr, mqb       registered destination, result, store data
module exe_stage_mul #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned ALUC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic              ealuimm,
    input  logic [ALUC_W-1:0] ealuc,
    input  logic [REG_AW-1:0] edestReg,
    input  logic [DATA_W-1:0] eqa,
    input  logic [DATA_W-1:0] eqb,
    input  logic [DATA_W-1:0] eimm32,
    output logic              estall,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [REG_AW-1:0] mdestReg,
    output logic [DATA_W-1:0] mr,
    output logic [DATA_W-1:0] mqb
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    localparam logic [ALUC_W-1:0] OP_ADD  = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] OP_SUB  = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] OP_AND  = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] OP_OR   = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] OP_XOR  = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] OP_SLL  = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] OP_SRL  = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] OP_SRA  = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] OP_SLT  = ALUC_W'(8);
    localparam logic [ALUC_W-1:0] OP_SLTU = ALUC_W'(9);
    localparam logic [ALUC_W-1:0] OP_LUI  = ALUC_W'(10);
    localparam logic [ALUC_W-1:0] OP_MUL  = ALUC_W'(11);

    logic [DATA_W-1:0] opb_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              stall_c;
    logic              mul_done_c;
    logic [DATA_W-1:0] mul_res_c;

    logic              mwreg_d,  mwreg_q;
    logic              mm2reg_d, mm2reg_q;
    logic              mwmem_d,  mwmem_q;
    logic [REG_AW-1:0] mdest_d,  mdest_q;
    logic [DATA_W-1:0] mr_d,     mr_q;
    logic [DATA_W-1:0] mqb_d,    mqb_q;

    // Single-cycle ALU; MUL is produced by the FSM, so its ALU slot is 0.
    always_comb begin
        opb_c     = ealuimm ? eimm32 : eqb;
        alu_res_c = '0;
        case (ealuc)
            OP_ADD:  alu_res_c = eqa + opb_c;
            OP_SUB:  alu_res_c = eqa - opb_c;
            OP_AND:  alu_res_c = eqa & opb_c;
            OP_OR:   alu_res_c = eqa | opb_c;
            OP_XOR:  alu_res_c = eqa ^ opb_c;
            OP_SLL:  alu_res_c = eqa << opb_c[SHAMT_W-1:0];
            OP_SRL:  alu_res_c = eqa >> opb_c[SHAMT_W-1:0];
            OP_SRA:  alu_res_c = DATA_W'($signed(eqa) >>> opb_c[SHAMT_W-1:0]);
            // Signed compare directly rather than via a-b, so overflow cannot flip it
            OP_SLT:  alu_res_c = DATA_W'($signed(eqa) < $signed(opb_c));
            OP_SLTU: alu_res_c = DATA_W'(eqa < opb_c);
            OP_LUI:  alu_res_c = opb_c << 16;
            OP_MUL:  alu_res_c = '0;
            default: alu_res_c = '0;
        endcase
    end

`ifdef EXE_MUL_EN
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // Multiplier state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Shift-add sequencing: operands latched in IDLE, DATA_W fixed steps in BUSY
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        mul_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ealuc == OP_MUL) begin
                    stall_c  = 1'b1;
                    mcand_d  = eqa;
                    mplier_d = opb_c;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                mul_done_c = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mul_res_c = acc_q;
`else
    assign stall_c    = 1'b0;
    assign mul_done_c = 1'b0;
    assign mul_res_c  = '0;
`endif

    // No stall is requested while reset is held
    assign estall = rst_n & stall_c;

    // EXE/MEM next values: bubble while stalling, product on the DONE cycle
    always_comb begin
        mwreg_d  = ewreg;
        mm2reg_d = em2reg;
        mwmem_d  = ewmem;
        mdest_d  = edestReg;
        mr_d     = alu_res_c;
        mqb_d    = eqb;
        if (mul_done_c) begin
            mr_d = mul_res_c;
        end
        if (stall_c) begin
            mwreg_d  = 1'b0;
            mm2reg_d = 1'b0;
            mwmem_d  = 1'b0;
            mdest_d  = '0;
            mr_d     = '0;
            mqb_d    = '0;
        end
    end

    // EXE/MEM pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mdest_q  <= '0;
            mr_q     <= '0;
            mqb_q    <= '0;
        end else begin
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            mdest_q  <= mdest_d;
            mr_q     <= mr_d;
            mqb_q    <= mqb_d;
        end
    end

    assign mwreg    = mwreg_q;
    assign mm2reg   = mm2reg_q;
    assign mwmem    = mwmem_q;
    assign mdestReg = mdest_q;
    assign mr       = mr_q;
    assign mqb      = mqb_q;

endmodule

// File: tb/tb_exe_stage_mul.sv
// tb_exe_stage_mul: directed self-checking bench for exe_stage_mul.
// Multiplier scenarios run when EXE_MUL_EN is defined; otherwise the bench
// checks that aluc B behaves as an unused code.
module tb_exe_stage_mul;

    logic        clk;
    logic        rst_n;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  edestReg;
    logic [31:0] eqa, eqb, eimm32;
    logic        estall;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mdestReg;
    logic [31:0] mr, mqb;

    int n_cmp;
    int n_fail;

    exe_stage_mul dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ewmem    (ewmem),
        .ealuimm  (ealuimm),
        .ealuc    (ealuc),
        .edestReg (edestReg),
        .eqa      (eqa),
        .eqb      (eqb),
        .eimm32   (eimm32),
        .estall   (estall),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mdestReg (mdestReg),
        .mr       (mr),
        .mqb      (mqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic wr, input logic m2r, input logic wm, input logic sel,
                         input logic [3:0] op, input logic [4:0] dest,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        ewreg    = wr;
        em2reg   = m2r;
        ewmem    = wm;
        ealuimm  = sel;
        ealuc    = op;
        edestReg = dest;
        eqa      = a;
        eqb      = b;
        eimm32   = imm;
        #1;
    endtask

    task automatic test_reset();
        logic [71:0] m_all;
        rst_n = 1'b0;
        set_e(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              5'($urandom), $urandom, $urandom, $urandom);
        step();
        step();
        m_all = {mwreg, mm2reg, mwmem, mdestReg, mr, mqb};
        n_cmp++;
        if (m_all !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_m_outputs: got %h expected 0", m_all);
        end
        n_cmp++;
        if (estall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_estall: got %b expected 0", estall);
        end
        // First instruction after release appears at the next edge
        rst_n = 1'b1;
        set_e(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 5'd1, 32'd1, 32'd0, 32'd2);
        step();
        n_cmp++;
        if ({mwreg, mdestReg, mr} !== {1'b1, 5'd1, 32'd3}) begin
            n_fail++;
            $display("FAIL reset_release_add: got wreg=%b dest=%0d mr=%h expected 1/1/00000003",
                     mwreg, mdestReg, mr);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  op_t [16];
        logic [31:0] a_t  [16];
        logic [31:0] b_t  [16];
        logic [31:0] e_t  [16];
        logic [31:0] qb, imm;
        logic        sel;
        op_t[0]  = 4'h0; a_t[0]  = 32'h7FFFFFFF; b_t[0]  = 32'h00000001; e_t[0]  = 32'h80000000;
        op_t[1]  = 4'h1; a_t[1]  = 32'h00000000; b_t[1]  = 32'h00000001; e_t[1]  = 32'hFFFFFFFF;
        op_t[2]  = 4'h8; a_t[2]  = 32'h80000000; b_t[2]  = 32'h00000001; e_t[2]  = 32'h00000001;
        op_t[3]  = 4'h7; a_t[3]  = 32'h80000000; b_t[3]  = 32'h00000004; e_t[3]  = 32'hF8000000;
        op_t[4]  = 4'h2; a_t[4]  = 32'hF0F0F0F0; b_t[4]  = 32'hFF00FF00; e_t[4]  = 32'hF000F000;
        op_t[5]  = 4'h3; a_t[5]  = 32'hF0F0F0F0; b_t[5]  = 32'h0F0F0000; e_t[5]  = 32'hFFFFF0F0;
        op_t[6]  = 4'h4; a_t[6]  = 32'hFFFF0000; b_t[6]  = 32'h0F0F0F0F; e_t[6]  = 32'hF0F00F0F;
        op_t[7]  = 4'h5; a_t[7]  = 32'h00000001; b_t[7]  = 32'h00000024; e_t[7]  = 32'h00000010;
        op_t[8]  = 4'h6; a_t[8]  = 32'h80000000; b_t[8]  = 32'h0000001F; e_t[8]  = 32'h00000001;
        op_t[9]  = 4'h9; a_t[9]  = 32'h80000000; b_t[9]  = 32'h00000001; e_t[9]  = 32'h00000000;
        op_t[10] = 4'h8; a_t[10] = 32'h7FFFFFFF; b_t[10] = 32'h80000000; e_t[10] = 32'h00000000;
        op_t[11] = 4'hA; a_t[11] = 32'hFFFFFFFF; b_t[11] = 32'h00001234; e_t[11] = 32'h12340000;
        op_t[12] = 4'hC; a_t[12] = 32'h00000005; b_t[12] = 32'h00000006; e_t[12] = 32'h00000000;
        op_t[13] = 4'hF; a_t[13] = 32'hFFFFFFFF; b_t[13] = 32'hFFFFFFFF; e_t[13] = 32'h00000000;
        op_t[14] = 4'h9; a_t[14] = 32'h00000001; b_t[14] = 32'h80000000; e_t[14] = 32'h00000001;
        op_t[15] = 4'h7; a_t[15] = 32'h7FFFFFFF; b_t[15] = 32'h00000001; e_t[15] = 32'h3FFFFFFF;
        for (int i = 0; i < 16; i++) begin
            // Odd vectors take B from the immediate; the unused source holds ~B
            sel = (i % 2) == 1;
            qb  = sel ? ~b_t[i] : b_t[i];
            imm = sel ? b_t[i] : ~b_t[i];
            set_e(1'b1, 1'b0, 1'b0, sel, op_t[i], 5'(i), a_t[i], qb, imm);
            step();
            n_cmp++;
            if ({mwreg, mwmem, mdestReg, mr, mqb} !== {1'b1, 1'b0, 5'(i), e_t[i], qb}) begin
                n_fail++;
                $display("FAIL alu_vec%0d op=%h: got wreg=%b wmem=%b dest=%0d mr=%h mqb=%h expected mr=%h mqb=%h dest=%0d",
                         i, op_t[i], mwreg, mwmem, mdestReg, mr, mqb, e_t[i], qb, i);
            end
        end
    endtask

    task automatic test_store();
        set_e(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 5'd0, 32'h100, 32'hDEAD, 32'h8);
        step();
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, mr, mqb} !== {1'b0, 1'b0, 1'b1, 32'h108, 32'hDEAD}) begin
            n_fail++;
            $display("FAIL store: got wreg=%b m2reg=%b wmem=%b mr=%h mqb=%h expected 0/0/1/00000108/0000dead",
                     mwreg, mm2reg, mwmem, mr, mqb);
        end
        set_e(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 5'd9, 32'h200, 32'h55, 32'hFFFFFFFC);
        step();
        n_cmp++;
        if ({mwreg, mm2reg, mwmem, mdestReg, mr, mqb} !== {1'b1, 1'b1, 1'b0, 5'd9, 32'h1FC, 32'h55}) begin
            n_fail++;
            $display("FAIL load: got wreg=%b m2reg=%b wmem=%b dest=%0d mr=%h mqb=%h expected 1/1/0/9/000001fc/00000055",
                     mwreg, mm2reg, mwmem, mdestReg, mr, mqb);
        end
    endtask

`ifdef EXE_MUL_EN
    task automatic test_mul();
        int stalls;
        bit done;
        set_e(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 5'd3, 32'h12345, 32'h1000, 32'h0);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (estall !== 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                step();
                n_cmp++;
                if ({mwreg, mm2reg, mwmem, mdestReg, mr, mqb} !== 72'd0) begin
                    n_fail++;
                    $display("FAIL mul_bubble%0d: got wreg=%b dest=%0d mr=%h mqb=%h expected all 0",
                             i, mwreg, mdestReg, mr, mqb);
                end
            end
        end
        n_cmp++;
        if (stalls != 33) begin
            n_fail++;
            $display("FAIL mul_stall_len: got %0d cycles expected 33", stalls);
        end
        step();
        n_cmp++;
        if ({mwreg, mdestReg, mr} !== {1'b1, 5'd3, 32'h12345000}) begin
            n_fail++;
            $display("FAIL mul_result: got wreg=%b dest=%0d mr=%h expected 1/3/12345000",
                     mwreg, mdestReg, mr);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        bit done;
        set_e(1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 5'd4, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (estall !== 1'b1) done = 1'b1;
            else begin stalls++; step(); end
        end
        n_cmp++;
        if (stalls != 33) begin
            n_fail++;
            $display("FAIL b2b_first_stall_len: got %0d expected 33", stalls);
        end
        step();
        n_cmp++;
        if ({mwreg, mdestReg, mr} !== {1'b1, 5'd4, 32'h1}) begin
            n_fail++;
            $display("FAIL b2b_first_result: got wreg=%b dest=%0d mr=%h expected 1/4/00000001",
                     mwreg, mdestReg, mr);
        end
        // Second MUL presented immediately after the DONE cycle
        set_e(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 5'd5, 32'h0, 32'h7, 32'h0);
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (estall !== 1'b1) done = 1'b1;
            else begin stalls++; step(); end
        end
        n_cmp++;
        if (stalls != 33) begin
            n_fail++;
            $display("FAIL b2b_second_stall_len: got %0d expected 33", stalls);
        end
        step();
        n_cmp++;
        if ({mwreg, mdestReg, mr} !== {1'b1, 5'd5, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got wreg=%b dest=%0d mr=%h expected 1/5/00000000",
                     mwreg, mdestReg, mr);
        end
    endtask

    task automatic test_mul_reset();
        set_e(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 5'd6, 32'd5, 32'd6, 32'd0);
        for (int i = 0; i < 11; i++) step();
        n_cmp++;
        if (estall !== 1'b1) begin
            n_fail++;
            $display("FAIL mulrst_busy_stall: got %b expected 1", estall);
        end
        rst_n = 1'b0;
        #1;
        step();
        n_cmp++;
        if ({estall, mwreg, mm2reg, mwmem, mdestReg, mr, mqb} !== 73'd0) begin
            n_fail++;
            $display("FAIL mulrst_outputs: got stall=%b wreg=%b dest=%0d mr=%h mqb=%h expected all 0",
                     estall, mwreg, mdestReg, mr, mqb);
        end
        rst_n = 1'b1;
        set_e(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd7, 32'd5, 32'd6, 32'd0);
        n_cmp++;
        if (estall !== 1'b0) begin
            n_fail++;
            $display("FAIL mulrst_idle_stall: got %b expected 0", estall);
        end
        step();
        n_cmp++;
        if ({mwreg, mdestReg, mr} !== {1'b1, 5'd7, 32'd11}) begin
            n_fail++;
            $display("FAIL mulrst_next_add: got wreg=%b dest=%0d mr=%h expected 1/7/0000000b",
                     mwreg, mdestReg, mr);
        end
    endtask
`else
    task automatic test_mul_disabled();
        set_e(1'b1, 1'b0, 1'b0, 1'b0, 4'hB, 5'd2, 32'd3, 32'd4, 32'd0);
        n_cmp++;
        if (estall !== 1'b0) begin
            n_fail++;
            $display("FAIL nomul_stall: got %b expected 0", estall);
        end
        step();
        n_cmp++;
        if ({estall, mwreg, mdestReg, mr, mqb} !== {1'b0, 1'b1, 5'd2, 32'd0, 32'd4}) begin
            n_fail++;
            $display("FAIL nomul_result: got stall=%b wreg=%b dest=%0d mr=%h mqb=%h expected 0/1/2/00000000/00000004",
                     estall, mwreg, mdestReg, mr, mqb);
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_e(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_alu();
        test_store();
`ifdef EXE_MUL_EN
        test_mul();
        test_back_to_back();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
